// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, flag bit positions and FSM state
//               encoding for the handshaked sequential ALU (alu_seq).
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Opcode encoding, unchanged from the single-cycle execute ALU plus MUL
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // Flag register layout {Z,C,V,N}
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_if
// Description : Handshake bundle for alu_seq.
//   in_valid/in_ready   : operation handshake (producer -> ALU)
//   src_a, src_b        : operands (WIDTH bits)
//   alu_op, s_bit       : opcode and flag-update request
//   out_valid/out_ready : result handshake (ALU -> consumer)
//   result_q, status_q  : registered result and {Z,C,V,N} flag register
//   Modports: master = operation producer / result consumer, slave = ALU.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       alu_op;
  logic             s_bit;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       status_q;

  modport master (
    output in_valid, src_a, src_b, alu_op, s_bit, out_ready,
    input  in_ready, out_valid, result_q, status_q
  );

  modport slave (
    input  in_valid, src_a, src_b, alu_op, s_bit, out_ready,
    output in_ready, out_valid, result_q, status_q
  );
endinterface
`default_nettype wire

// File: rtl/alu_seq_mul_iter.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_iter
// Description : Iterative shift-add multiplier producing the low WIDTH bits
//               of a*b. One partial product per cycle; WIDTH steps in total.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : latch a_i/b_i, clear accumulator and step counter
//   a_i, b_i    : operands (sampled only on start_i)
//   done_o      : high during the final step; product_o valid in that cycle
//   product_o   : low WIDTH bits of the product (valid with done_o)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start_i,
  input  wire logic [WIDTH-1:0] a_i,
  input  wire logic [WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [WIDTH-1:0]      product_o
);

  logic [WIDTH-1:0] mcand_q;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right each step
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] acc_d;

  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  // The final step's sum is handed out directly so the owner can register it
  // on the same edge, keeping latency at exactly WIDTH cycles.
  assign done_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign product_o = acc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      mcand_q  <= a_i;
      mplier_q <= b_i;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Handshaked execute-stage ALU with registered result, internal
//               NZCV flag register and optional iterative MUL.
//   clk, rst : clock, synchronous active-high reset
//   bus      : alu_seq_if.slave (in_valid/in_ready, src_a, src_b, alu_op,
//              s_bit, out_valid/out_ready, result_q, status_q {Z,C,V,N})
//   Optional : define ALU_SEQ_MUL_EN to build the MUL_BUSY state and the
//              iterative multiplier; otherwise opcode 1010 is undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input wire logic  clk,
  input wire logic  rst,
  alu_seq_if.slave  bus
);

  if (WIDTH < 4 || CNT_W != $clog2(WIDTH) + 1) begin : g_param_chk
    $error("alu_seq: WIDTH must be >= 4 and CNT_W must not be overridden");
  end

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       status_q, status_d;

  logic             in_ready;
  logic             accept;
  logic [WIDTH-1:0] op_res;
  logic [3:0]       op_flags;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic             arith;

  assign in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.result_q  = result_q;
  assign bus.status_q  = status_q;

  // Single-cycle decode. Subtraction is a + ~b + cin, so the carry out is
  // already the "not borrow" convention and SBC simply feeds C as cin.
  always_comb begin
    op_res   = '0;
    op_flags = '0;
    b_eff    = bus.src_b;
    cin      = 1'b0;
    arith    = 1'b0;
    case (bus.alu_op)
      OP_MOV: op_res = bus.src_b;
      OP_ADD: arith = 1'b1;
      OP_ADC: begin arith = 1'b1; cin = status_q[FLAG_C]; end
      OP_SUB: begin arith = 1'b1; b_eff = ~bus.src_b; cin = 1'b1; end
      OP_SBC: begin arith = 1'b1; b_eff = ~bus.src_b; cin = status_q[FLAG_C]; end
      OP_AND: op_res = bus.src_a & bus.src_b;
      OP_ORR: op_res = bus.src_a | bus.src_b;
      OP_EOR: op_res = bus.src_a ^ bus.src_b;
      OP_MVN: op_res = ~bus.src_b;
      OP_MUL: op_res = '0;  // handled by the multiplier when it is built
      default: op_res = '0;
    endcase
    sum = {1'b0, bus.src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    if (arith) begin
      op_res           = sum[WIDTH-1:0];
      op_flags[FLAG_C] = sum[WIDTH];
      op_flags[FLAG_V] = (bus.src_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                         (op_res[WIDTH-1] != bus.src_a[WIDTH-1]);
    end
    op_flags[FLAG_Z] = (op_res == '0);
    op_flags[FLAG_N] = op_res[WIDTH-1];
  end

`ifdef ALU_SEQ_MUL_EN
  logic             sbit_q, sbit_d;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  assign mul_start = accept && (bus.alu_op == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (mul_start),
    .a_i       (bus.src_a),
    .b_i       (bus.src_b),
    .done_o    (mul_done),
    .product_o (mul_prod)
  );
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    status_d    = status_q;
`ifdef ALU_SEQ_MUL_EN
    sbit_d      = sbit_q;
`endif
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef ALU_SEQ_MUL_EN
          if (bus.alu_op == OP_MUL) begin
            state_d = ST_MUL_BUSY;
            sbit_d  = bus.s_bit;
          end else
`endif
          begin
            result_d    = op_res;
            out_valid_d = 1'b1;
            if (bus.s_bit) begin
              status_d = op_flags;
            end
          end
        end
      end
      ST_MUL_BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_done) begin
          state_d     = ST_IDLE;
          result_d    = mul_prod;
          out_valid_d = 1'b1;
          if (sbit_q) begin
            // MUL leaves C and V untouched
            status_d[FLAG_Z] = (mul_prod == '0);
            status_d[FLAG_N] = mul_prod[WIDTH-1];
          end
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      status_q    <= 4'b0000;
`ifdef ALU_SEQ_MUL_EN
      sbit_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      status_q    <= status_d;
`ifdef ALU_SEQ_MUL_EN
      sbit_q      <= sbit_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Self-checking bench for alu_seq: directed vector table plus
//               hand-written back-to-back, stall, MUL and reset sequences.
//               MUL checks adapt to ALU_SEQ_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

  localparam int W = 32;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] exp_res;
    logic [3:0]   exp_stat;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.alu_op   = op;
    bus.src_a    = a;
    bus.src_b    = b;
    bus.s_bit    = s;
    bus.in_valid = 1'b1;
  endtask

  // Present an op, wait (bounded) for in_ready, then step past the accept edge.
  task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    int n;
    drive(op, a, b, s);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 100) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready never rose for op %b", op);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    int lat;
    total = 0;
    bad   = 0;

    vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 32'h8000_0000, 4'b0011};
    vecs[1]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b1100};
    vecs[2]  = '{4'b0011, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 4'b0000};
    vecs[3]  = '{4'b0100, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 4'b0001};
    vecs[4]  = '{4'b0101, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0006, 4'b0100};
    vecs[5]  = '{4'b0101, 32'h0000_000A, 32'h0000_0003, 1'b1, 32'h0000_0007, 4'b0100};
    vecs[6]  = '{4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, 32'hF000_F000, 4'b0100};
    vecs[7]  = '{4'b0111, 32'h0F00_0000, 32'h00F0_0000, 1'b1, 32'h0FF0_0000, 4'b0000};
    vecs[8]  = '{4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 4'b1000};
    vecs[9]  = '{4'b1001, 32'h1234_5678, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 4'b0001};
    vecs[10] = '{4'b0001, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h1234_5678, 4'b0000};
    vecs[11] = '{4'b1111, 32'h0000_0005, 32'h0000_0006, 1'b1, 32'h0000_0000, 4'b1000};
    vecs[12] = '{4'b0100, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 4'b0100};
    vecs[13] = '{4'b0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 4'b0100};
    vecs[14] = '{4'b1111, 32'h0000_0009, 32'h0000_0003, 1'b0, 32'h0000_0000, 4'b0100};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_op    = 4'b0000;
    bus.src_a     = '0;
    bus.src_b     = '0;
    bus.s_bit     = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_out_valid", W'(bus.out_valid), 32'd0);
    chk("reset_result", bus.result_q, 32'd0);
    chk("reset_status", W'(bus.status_q), 32'd0);
    chk("reset_in_ready", W'(bus.in_ready), 32'd1);

    // Vector table: every op yields out_valid one edge after accept
    for (int i = 0; i < 15; i++) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].s);
      chk($sformatf("vec%0d_valid", i), W'(bus.out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), bus.result_q, vecs[i].exp_res);
      chk($sformatf("vec%0d_status", i), W'(bus.status_q), W'(vecs[i].exp_stat));
    end

    // Back-to-back ADD then ADC with no bubble
    drive(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    @(posedge clk); #1;
    chk("b2b_add_result", bus.result_q, 32'h0);
    chk("b2b_add_status", W'(bus.status_q), 32'hC);
    chk("b2b_in_ready", W'(bus.in_ready), 32'd1);
    drive(4'b0011, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("b2b_adc_valid", W'(bus.out_valid), 32'd1);
    chk("b2b_adc_result", bus.result_q, 32'h1);
    @(posedge clk); #1;
    chk("b2b_drain_valid", W'(bus.out_valid), 32'd0);

    // Output stall: SUB 5-7 held while out_ready=0, pending MOV waits
    bus.out_ready = 1'b0;
    send(4'b0100, 32'd5, 32'd7, 1'b1);
    drive(4'b0001, 32'h0, 32'h0000_0055, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), W'(bus.out_valid), 32'd1);
      chk($sformatf("stall%0d_result", k), bus.result_q, 32'hFFFF_FFFE);
      chk($sformatf("stall%0d_in_ready", k), W'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_in_ready", W'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("stall_next_valid", W'(bus.out_valid), 32'd1);
    chk("stall_next_result", bus.result_q, 32'h0000_0055);
    chk("stall_next_status", W'(bus.status_q), 32'h1);
    @(posedge clk); #1;

    // Set V and N so MUL's C/V preservation is observable
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    chk("premul_status", W'(bus.status_q), 32'h3);
    @(posedge clk); #1;

`ifdef ALU_SEQ_MUL_EN
    send(4'b1010, 32'h0001_0000, 32'h0001_0000, 1'b1);
    bus.src_a = 32'hFFFF_FFFF;
    bus.src_b = 32'hFFFF_FFFF;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      chk($sformatf("mul_busy%0d_in_ready", lat), W'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("mul_latency", W'(lat), 32'd32);
    chk("mul_result", bus.result_q, 32'h0);
    chk("mul_status", W'(bus.status_q), 32'hA);
    @(posedge clk); #1;

    send(4'b1010, 32'h0000_1234, 32'h0000_5678, 1'b1);
    bus.src_a = 32'h0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("mul2_latency", W'(lat), 32'd32);
    chk("mul2_result", bus.result_q, 32'h0626_0060);
    chk("mul2_status", W'(bus.status_q), 32'h2);
    @(posedge clk); #1;

    // Reset during MUL: everything cleared, no late result
    send(4'b1010, 32'h0000_0003, 32'h0000_0005, 1'b1);
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`else
    // MUL opcode is undefined in this build: single-cycle, result 0, Z=1
    send(4'b1010, 32'h0000_0003, 32'h0000_0004, 1'b1);
    chk("mul_undef_valid", W'(bus.out_valid), 32'd1);
    chk("mul_undef_result", bus.result_q, 32'h0);
    chk("mul_undef_status", W'(bus.status_q), 32'h8);
    @(posedge clk); #1;

    // Reset while a result is being held
    send(4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b1);
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    lat = 0;
`endif
    chk("rst_mid_valid", W'(bus.out_valid), 32'd0);
    chk("rst_mid_result", bus.result_q, 32'h0);
    chk("rst_mid_status", W'(bus.status_q), 32'h0);
    chk("rst_mid_in_ready", W'(bus.in_ready), 32'd1);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) lat++;
    end
    chk("rst_no_late_result", W'(lat), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle execute-stage ALU.
- Adds a registered output stage and valid/ready handshakes on input and output.
- Holds an internal NZCV flag register. ADC/SBC read their carry from this register, not from a port.
- Adds a multi-cycle iterative MUL opcode.
- Sits in the Exe stage between the operand muxes and the EX/MEM register; a stall is generated whenever in_ready is low.

Parameters:
- WIDTH, 32: datapath width in bits; must be at least 4.
- CNT_W, $clog2(WIDTH)+1: width of the multiply step counter; derived, do not override.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B (shifter output).
- alu_op  input  4  opcode.
- s_bit  input  1  update flag register when this operation completes.
- out_valid  output  1  result_q is valid.
- out_ready  input  1  consumer accepts the result.
- result_q  output  WIDTH  registered result.
- status_q  output  4  flag register, bit order {Z,C,V,N}.

Behaviour:
- Reset (synchronous, active-high; also applies mid-operation):
  - state=IDLE, out_valid=0, result_q=0, status_q=4'b0000, step counter=0.
  - Any in-flight MUL is discarded.
- Opcodes (same encoding as the existing ALU):
  - 0001 MOV, 0010 ADD, 0011 ADC, 0100 SUB, 0101 SBC, 0110 AND, 0111 ORR, 1000 EOR, 1001 MVN.
  - New: 1010 MUL (low WIDTH bits of src_a*src_b).
  - Any other opcode: result 0, C=V=0.
- Arithmetic (WIDTH+1-bit internal):
  - ADD/ADC: C = carry out.
  - SUB/SBC: C = NOT borrow. SBC subtracts ~status_q.C.
  - V = signed overflow on bit WIDTH-1.
  - Logic ops and MOV/MVN: C=V=0.
  - MUL: C and V preserved from status_q.
  - All ops: Z = (result==0), N = result[WIDTH-1].
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - An operation is accepted on an edge where in_valid && in_ready.
  - out_valid holds, with result_q and status_q stable, until out_valid && out_ready.
  - Result accept and new input accept may occur on the same edge (back-to-back, 1 op/cycle throughput).
  - If an input is accepted without a simultaneous output handshake, out_valid must already be 0.
- Single-cycle ops: result_q and out_valid=1 are written on the accept edge, so latency is 1.
- FSM:
  - IDLE: accept of MUL goes to MUL_BUSY. Operands are latched, the accumulator is cleared, and counter=0.
  - MUL_BUSY: one shift-add step per cycle.
    - When counter reaches WIDTH-1, the final step writes result_q, sets out_valid, and returns to IDLE.
    - MUL latency is exactly WIDTH cycles from the accept edge.
    - in_ready=0 throughout MUL_BUSY.
  - Operands may change after accept without effect.
- Flags:
  - status_q is updated only on the edge the result is written, and only if the latched s_bit=1.
  - With s_bit=0, status_q is unchanged.
  - ADC/SBC read status_q as it stands at their accept edge, so a flag-setting op immediately before them is visible (no hazard).

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined: MUL_BUSY state, operand latches, and iterative multiplier are built as described above.
- Undefined:
  - Opcode 1010 is treated as undefined: single-cycle, result 0, C=V=0, Z=1, N=0.
  - MUL_BUSY is never entered and in_ready depends only on the output stage.

Decomposition:
- Package alu_pkg:
  - Opcode localparams (OP_MOV..OP_MUL).
  - Flag bit indices (FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_N=0).
  - FSM state encoding (ST_IDLE, ST_MUL_BUSY).
- Sub-module alu_mul_iter:
  - Iterative shift-add multiplier: start/operands in, done/product out, WIDTH-parametrised.
  - Instantiated only under ALU_SEQ_MUL_EN.
- The combinational op decode stays in alu_seq.

Test Plan:
1. ADD 0x7FFFFFFF+0x00000001, s_bit=1 -> result_q=0x80000000, status_q=4'b0011, out_valid one cycle after accept.
2. ADD 0xFFFFFFFF+0x00000001 s_bit=1, then back-to-back ADC 0+0 -> first result 0 with status_q=4'b1100; second result 0x00000001; no bubble between accepts.
3. MUL 0x00010000*0x00010000 (MUL_EN) -> in_ready=0 for 32 cycles, out_valid exactly 32 cycles after accept, result_q=0, Z=1, C/V unchanged.
4. Hold out_ready=0 for 3 cycles after SUB 5-7 -> result_q=0xFFFFFFFE held stable, in_ready=0; next op accepted on the handshake edge.
5. Assert rst at cycle 10 of a MUL -> next cycle: out_valid=0, result_q=0, status_q=0, in_ready=1; no late result appears.
6. Flags then MOV: status_q=4'b0100, then MOV 0 with s_bit=0 -> result_q=0, status_q still 4'b0100; undefined opcode 1111 -> result_q=0.
